// File: rtl/ram_arbiter_pkg.sv
// Shared widths, port IDs and pipeline record for the two-port RAM arbiter.
// Addresses are 16 bits wide so that every implemented byte (0x0000..0xC686) and the first out-of-range address can be expressed.
package ram_arbiter_pkg;

    localparam int ADDR_W        = 16;
    localparam int DATA_W        = 8;
    localparam int MEM_DEPTH_DEF = 50823;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_DMA = 1'b1
    } port_e;

    typedef struct packed {
        logic  vld;
        port_e owner;
        logic  in_range;
    } cmd_t;

    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr, input int unsigned depth);
        return {{(32-ADDR_W){1'b0}}, addr} < depth;
    endfunction

endpackage

// File: rtl/ram_arbiter_rr.sv
// rr_arbiter2: 2-way request to one-hot grant, combinational; last-granted pointer or fixed priority.
// Grants are forced low during reset; the pointer restarts at the DMA port so the CPU wins the first tie.
import ram_arbiter_pkg::*;

module rr_arbiter2 #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    port_e last_q, last_d;
    logic  p0_wins;

    always_comb begin
        gnt_o   = 2'b00;
        last_d  = last_q;
        p0_wins = req_i[0] & (~req_i[1] | FIXED_PRIO | (last_q == PORT_DMA));
        if (!rst_i) begin
            gnt_o[0] = p0_wins;
            gnt_o[1] = req_i[1] & ~p0_wins;
        end
        if (gnt_o[0]) begin
            last_d = PORT_CPU;
        end else if (gnt_o[1]) begin
            last_d = PORT_DMA;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= PORT_DMA;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a synchronous read-before-write byte RAM; one access per clock.
// Grant is same-cycle, completion 2 cycles later; a losing port simply holds its request.
import ram_arbiter_pkg::*;

module ram_arbiter #(
    parameter int ARB_MODE  = 0,
    parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_done,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_err,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_done,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_write_en,
    output logic              ram_read_en,
    input  logic [DATA_W-1:0] ram_data_out
);

    logic [1:0]        gnt;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_we;
    logic              sel_in_rng;

    cmd_t              cmd_q, cmd_d;
    cmd_t              resp_q, resp_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_din_q, ram_din_d;
    logic              ram_we_q, ram_we_d;
    logic              ram_re_q, ram_re_d;

    rr_arbiter2 #(
        .FIXED_PRIO (ARB_MODE != 0)
    ) u_arb (
        .clk_i (clk),
        .rst_i (rst),
        .req_i ({p1_req, p0_req}),
        .gnt_o (gnt)
    );

    assign p0_gnt = gnt[0];
    assign p1_gnt = gnt[1];

    always_comb begin
        sel_addr   = gnt[1] ? p1_addr  : p0_addr;
        sel_wdata  = gnt[1] ? p1_wdata : p0_wdata;
        sel_we     = gnt[1] ? p1_we    : p0_we;
        sel_in_rng = addr_in_range(sel_addr, MEM_DEPTH);

        cmd_d      = '0;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        ram_we_d   = 1'b0;
        ram_re_d   = 1'b0;
        if (|gnt) begin
            cmd_d.vld      = 1'b1;
            cmd_d.owner    = gnt[1] ? PORT_DMA : PORT_CPU;
            cmd_d.in_range = sel_in_rng;
            ram_addr_d     = sel_addr;
            ram_din_d      = sel_wdata;
            // Out-of-range writes are dropped here so they never reach the array.
            ram_we_d       = sel_we & sel_in_rng;
            ram_re_d       = ~sel_we;
        end
        resp_d = cmd_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q      <= '0;
            resp_q     <= '0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            ram_we_q   <= 1'b0;
            ram_re_q   <= 1'b0;
        end else begin
            cmd_q      <= cmd_d;
            resp_q     <= resp_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            ram_we_q   <= ram_we_d;
            ram_re_q   <= ram_re_d;
        end
    end

    assign ram_addr     = ram_addr_q;
    assign ram_data_in  = ram_din_q;
    assign ram_write_en = ram_we_q;
    assign ram_read_en  = ram_re_q;

    // RAM output is consumed combinationally in the response cycle.
    always_comb begin
        p0_done  = ~rst & resp_q.vld & (resp_q.owner == PORT_CPU);
        p1_done  = ~rst & resp_q.vld & (resp_q.owner == PORT_DMA);
        p0_err   = p0_done & ~resp_q.in_range;
        p1_err   = p1_done & ~resp_q.in_range;
        p0_rdata = (p0_done && resp_q.in_range) ? ram_data_out : '0;
        p1_rdata = (p1_done && resp_q.in_range) ? ram_data_out : '0;
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a round-robin and a fixed-priority instance share one stimulus stream,
// each with its own RAM; a transaction-level model predicts grants, RAM strobes and completions.
module tb_ram_arbiter;

    localparam int DEPTH = 50823;

    logic        clk;
    logic        rst;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [15:0] p0_addr, p1_addr;
    logic [7:0]  p0_wdata, p1_wdata;

    logic [1:0]  p0_gnt, p1_gnt, p0_done, p1_done, p0_err, p1_err, ram_we, ram_re;
    logic [7:0]  p0_rdata [2];
    logic [7:0]  p1_rdata [2];
    logic [7:0]  ram_din  [2];
    logic [7:0]  ram_dout [2];
    logic [15:0] ram_addr [2];

    int checks = 0;
    int errors = 0;
    int dc [2][2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ram_arbiter #(
            .ARB_MODE  (g),
            .MEM_DEPTH (DEPTH)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .p0_req       (p0_req),
            .p0_we        (p0_we),
            .p0_addr      (p0_addr),
            .p0_wdata     (p0_wdata),
            .p0_gnt       (p0_gnt[g]),
            .p0_done      (p0_done[g]),
            .p0_rdata     (p0_rdata[g]),
            .p0_err       (p0_err[g]),
            .p1_req       (p1_req),
            .p1_we        (p1_we),
            .p1_addr      (p1_addr),
            .p1_wdata     (p1_wdata),
            .p1_gnt       (p1_gnt[g]),
            .p1_done      (p1_done[g]),
            .p1_rdata     (p1_rdata[g]),
            .p1_err       (p1_err[g]),
            .ram_addr     (ram_addr[g]),
            .ram_data_in  (ram_din[g]),
            .ram_write_en (ram_we[g]),
            .ram_read_en  (ram_re[g]),
            .ram_data_out (ram_dout[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d got=%0h want=%0h at %0t", nm, inst, act, exp, $time);
        end
    endtask

    // Synchronous read-before-write RAM, one per instance, output one cycle after address.
    logic [7:0] mem [2][65536];
    initial begin
        for (int i = 0; i < 2; i++)
            for (int a = 0; a < 65536; a++) mem[i][a] = 8'h00;
        mem[0][16'h0010] = 8'hA5;
        mem[1][16'h0010] = 8'hA5;
        forever begin
            @(posedge clk);
            for (int i = 0; i < 2; i++) begin
                ram_dout[i] <= mem[i][ram_addr[i]];
                if (ram_we[i]) mem[i][ram_addr[i]] <= ram_din[i];
            end
        end
    end

    // Transaction-level model: accesses are serialized in grant order, memory effect applied at grant.
    typedef struct {
        int         due;
        int         port;
        logic [7:0] rd;
        logic       err;
    } txn_t;

    txn_t       q [2][$];
    logic [7:0] mmem [2][65536];
    int         last [2];
    logic       e_we [2];
    logic       e_re [2];
    logic [15:0] e_addr [2];
    logic [7:0] e_din [2];

    initial begin
        txn_t       t;
        int         cyc;
        int         win;
        logic       ed0, ed1, ee0, ee1, w, inr;
        logic [7:0] er0, er1, d, old;
        logic [15:0] a;
        cyc = 0;
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 65536; k++) mmem[i][k] = 8'h00;
            mmem[i][16'h0010] = 8'hA5;
            last[i] = 1;
            e_we[i] = 1'b0; e_re[i] = 1'b0; e_addr[i] = 16'h0; e_din[i] = 8'h00;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                ed0 = 1'b0; ed1 = 1'b0; ee0 = 1'b0; ee1 = 1'b0; er0 = 8'h00; er1 = 8'h00;
                if (q[i].size() > 0 && q[i][0].due == cyc) begin
                    t = q[i].pop_front();
                    if (!rst) begin
                        if (t.port == 0) begin ed0 = 1'b1; ee0 = t.err; er0 = t.rd; end
                        else             begin ed1 = 1'b1; ee1 = t.err; er1 = t.rd; end
                    end
                end
                if (rst) q[i].delete();
                chk("p0_done", i, p0_done[i], ed0);
                chk("p1_done", i, p1_done[i], ed1);
                chk("p0_err", i, p0_err[i], ee0);
                chk("p1_err", i, p1_err[i], ee1);
                chk("p0_rdata", i, p0_rdata[i], er0);
                chk("p1_rdata", i, p1_rdata[i], er1);
                chk("ram_write_en", i, ram_we[i], e_we[i]);
                chk("ram_read_en", i, ram_re[i], e_re[i]);
                chk("ram_addr", i, ram_addr[i], e_addr[i]);
                chk("ram_data_in", i, ram_din[i], e_din[i]);

                // Instance i runs ARB_MODE=i: ties go to port 0 in fixed mode, else to the port not granted last.
                win = -1;
                if (!rst) begin
                    if (p0_req && p1_req) win = (i == 1) ? 0 : 1 - last[i];
                    else if (p0_req)      win = 0;
                    else if (p1_req)      win = 1;
                end
                chk("p0_gnt", i, p0_gnt[i], win == 0);
                chk("p1_gnt", i, p1_gnt[i], win == 1);

                if (rst) begin
                    e_we[i] = 1'b0; e_re[i] = 1'b0; e_addr[i] = 16'h0; e_din[i] = 8'h00;
                    last[i] = 1;
                end else if (win >= 0) begin
                    a   = (win == 1) ? p1_addr  : p0_addr;
                    w   = (win == 1) ? p1_we    : p0_we;
                    d   = (win == 1) ? p1_wdata : p0_wdata;
                    inr = int'(a) < DEPTH;
                    old = mmem[i][a];
                    if (w && inr) mmem[i][a] = d;
                    q[i].push_back('{due: cyc + 2, port: win, rd: inr ? old : 8'h00, err: !inr});
                    e_addr[i] = a; e_din[i] = d; e_we[i] = w & inr; e_re[i] = !w;
                    last[i] = win;
                end else begin
                    e_we[i] = 1'b0; e_re[i] = 1'b0;
                end
            end
            cyc++;
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic r0, input logic w0, input logic [15:0] a0, input logic [7:0] d0,
                       input logic r1, input logic w1, input logic [15:0] a1, input logic [7:0] d1);
        p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
        p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
    endtask

    task automatic idle();
        drv(1'b0, 1'b0, 16'h0, 8'h00, 1'b0, 1'b0, 16'h0, 8'h00);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin dc[i][0] = 0; dc[i][1] = 0; end
        rst = 1'b1;
        drv(1'b1, 1'b0, 16'h0010, 8'h00, 1'b1, 1'b0, 16'h0010, 8'h00);
        @(negedge clk);
        chk("lit_rst_gnt0", 0, p0_gnt[0], 1'b0);
        chk("lit_rst_gnt1", 0, p1_gnt[0], 1'b0);
        nxt();
        idle();
        nxt();
        rst = 1'b0;
        @(negedge clk);
        chk("lit_rst_addr", 0, ram_addr[0], 16'h0);
        chk("lit_rst_re", 0, ram_re[0], 1'b0);
        nxt();

        // Single read of a preloaded byte.
        drv(1'b1, 1'b0, 16'h0010, 8'h00, 1'b0, 1'b0, 16'h0, 8'h00);
        @(negedge clk);
        chk("lit_rd_gnt", 0, p0_gnt[0], 1'b1);
        nxt();
        idle();
        @(negedge clk);
        chk("lit_rd_ram_re", 0, ram_re[0], 1'b1);
        chk("lit_rd_ram_addr", 0, ram_addr[0], 16'h0010);
        nxt();
        @(negedge clk);
        chk("lit_rd_done", 0, p0_done[0], 1'b1);
        chk("lit_rd_data", 0, p0_rdata[0], 8'hA5);
        chk("lit_rd_err", 0, p0_err[0], 1'b0);
        nxt();

        // Write then read the same address from port 1.
        drv(1'b0, 1'b0, 16'h0, 8'h00, 1'b1, 1'b1, 16'h1234, 8'h3C);
        @(negedge clk);
        chk("lit_wr_gnt", 0, p1_gnt[0], 1'b1);
        nxt();
        drv(1'b0, 1'b0, 16'h0, 8'h00, 1'b1, 1'b0, 16'h1234, 8'h00);
        nxt();
        idle();
        @(negedge clk);
        chk("lit_wr_done", 0, p1_done[0], 1'b1);
        chk("lit_wr_old", 0, p1_rdata[0], 8'h00);
        nxt();
        @(negedge clk);
        chk("lit_rw_done", 0, p1_done[0], 1'b1);
        chk("lit_rw_new", 0, p1_rdata[0], 8'h3C);
        nxt();

        // Contention: both ports request for 6 cycles, then only port 1.
        for (int s = 0; s < 9; s++) begin
            if (s < 6)       drv(1'b1, 1'b0, 16'h0010, 8'h00, 1'b1, 1'b0, 16'h1234, 8'h00);
            else if (s == 6) drv(1'b0, 1'b0, 16'h0, 8'h00, 1'b1, 1'b0, 16'h1234, 8'h00);
            else             idle();
            @(negedge clk);
            if (s < 6) begin
                chk("lit_rr_g0", 0, p0_gnt[0], (s % 2) == 0);
                chk("lit_rr_g1", 0, p1_gnt[0], (s % 2) == 1);
                chk("lit_fp_g0", 1, p0_gnt[1], 1'b1);
                chk("lit_fp_g1", 1, p1_gnt[1], 1'b0);
            end
            if (s == 6) chk("lit_fp_p1_after_drop", 1, p1_gnt[1], 1'b1);
            if (s >= 2 && s <= 7) begin
                for (int i = 0; i < 2; i++) begin
                    dc[i][0] += int'(p0_done[i]);
                    dc[i][1] += int'(p1_done[i]);
                end
            end
            nxt();
        end
        chk("lit_rr_p0_dones", 0, dc[0][0], 3);
        chk("lit_rr_p1_dones", 0, dc[0][1], 3);
        chk("lit_fp_p0_dones", 1, dc[1][0], 6);
        chk("lit_fp_p1_dones", 1, dc[1][1], 0);

        // Out-of-range write, then the last valid address.
        drv(1'b1, 1'b1, 16'hC687, 8'hFF, 1'b0, 1'b0, 16'h0, 8'h00);
        nxt();
        drv(1'b1, 1'b0, 16'hC686, 8'h00, 1'b0, 1'b0, 16'h0, 8'h00);
        @(negedge clk);
        chk("lit_oor_no_we", 0, ram_we[0], 1'b0);
        nxt();
        drv(1'b1, 1'b1, 16'hC686, 8'h5A, 1'b0, 1'b0, 16'h0, 8'h00);
        @(negedge clk);
        chk("lit_oor_done", 0, p0_done[0], 1'b1);
        chk("lit_oor_err", 0, p0_err[0], 1'b1);
        chk("lit_oor_rdata", 0, p0_rdata[0], 8'h00);
        nxt();
        drv(1'b1, 1'b0, 16'hC686, 8'h00, 1'b0, 1'b0, 16'h0, 8'h00);
        @(negedge clk);
        chk("lit_top_err", 0, p0_err[0], 1'b0);
        chk("lit_top_done", 0, p0_done[0], 1'b1);
        nxt();
        idle();
        nxt();
        @(negedge clk);
        chk("lit_top_rd", 0, p0_rdata[0], 8'h5A);
        nxt();

        // Reset while two reads are in flight.
        drv(1'b1, 1'b0, 16'h0010, 8'h00, 1'b0, 1'b0, 16'h0, 8'h00);
        nxt();
        nxt();
        rst = 1'b1;
        idle();
        @(negedge clk);
        chk("lit_mid_rst_done", 0, p0_done[0], 1'b0);
        nxt();
        rst = 1'b0;
        @(negedge clk);
        chk("lit_post_rst_done", 0, p0_done[0], 1'b0);
        chk("lit_post_rst_re", 0, ram_re[0], 1'b0);
        chk("lit_post_rst_addr", 0, ram_addr[0], 16'h0);
        nxt();
        drv(1'b1, 1'b0, 16'h0010, 8'h00, 1'b1, 1'b0, 16'h1234, 8'h00);
        @(negedge clk);
        chk("lit_post_rst_tie_p0", 0, p0_gnt[0], 1'b1);
        chk("lit_post_rst_tie_p1", 0, p1_gnt[0], 1'b0);
        nxt();
        idle();
        repeat (4) nxt();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
